// File: rtl/adder_arbiter.sv
// Round-robin sharing of one registered 16-bit adder among NUM_REQ clients,
// returning tagged sums in issue order through a credit-checked FIFO.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ADD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*16-1:0] req_data_1_i,
    input  logic [NUM_REQ*16-1:0] req_data_2_i,
    output logic [15:0]           add_data_1_o,
    output logic [15:0]           add_data_2_o,
    input  logic [16:0]           add_sum_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [16:0]           rsp_sum_o,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic                  idle_o
);
    localparam int RSP_DEPTH = ADD_LAT + 1;
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int LAT_CW    = $clog2(ADD_LAT + 1);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant_id;
    logic               any_valid;
    logic               issue;
    logic               pop;
    logic               push;
    logic [ADD_LAT-1:0] tag_vld;
    logic [ID_W-1:0]    tag_id [ADD_LAT];
    logic [16:0]        fifo_sum [RSP_DEPTH];
    logic [ID_W-1:0]    fifo_id [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [LAT_CW-1:0]  inflight_cnt;

    function automatic logic [ID_W-1:0] rr_idx(
        input logic [ID_W-1:0] base,
        input int              off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[ID_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        grant_id  = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req_valid_i[rr_idx(ptr, i)]) begin
                any_valid = 1'b1;
                grant_id  = rr_idx(ptr, i);
            end
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int k = 0; k < ADD_LAT; k++)
            inflight_cnt = inflight_cnt + LAT_CW'(tag_vld[k]);
    end

    // Credit returned by a pop is usable in the same cycle.
    assign pop   = rsp_valid_o & rsp_ready_i;
    assign push  = tag_vld[ADD_LAT-1];
    assign issue = any_valid &&
                   (int'(inflight_cnt) + int'(fifo_cnt) - int'(pop) < RSP_DEPTH);

    always_comb begin
        req_ready_o  = '0;
        add_data_1_o = '0;
        add_data_2_o = '0;
        if (issue) begin
            req_ready_o[grant_id] = 1'b1;
            add_data_1_o = req_data_1_i[16*grant_id +: 16];
            add_data_2_o = req_data_2_i[16*grant_id +: 16];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr     <= '0;
            tag_vld <= '0;
            for (int k = 0; k < ADD_LAT; k++)
                tag_id[k] <= '0;
        end else begin
            if (issue)
                ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            tag_vld[0] <= issue;
            tag_id[0]  <= grant_id;
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int k = 0; k < RSP_DEPTH; k++) begin
                fifo_sum[k] <= '0;
                fifo_id[k]  <= '0;
            end
        end else begin
            assert (!(push && fifo_cnt == CNT_W'(RSP_DEPTH)));
            if (push) begin
                fifo_sum[wr_ptr] <= add_sum_i;
                fifo_id[wr_ptr]  <= tag_id[ADD_LAT-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rsp_valid_o = (fifo_cnt != '0);
    assign rsp_sum_o   = rsp_valid_o ? fifo_sum[rd_ptr] : '0;
    assign rsp_id_o    = rsp_valid_o ? fifo_id[rd_ptr] : '0;
    assign idle_o      = (inflight_cnt == '0) && (fifo_cnt == '0);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic,
// checked against a queue-based model of the sharing rules.
module tb_adder_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] d1;
    logic [NREQ*16-1:0] d2;
    logic [15:0]       add_d1;
    logic [15:0]       add_d2;
    logic [16:0]       add_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [16:0]       rsp_sum;
    logic [IDW-1:0]    rsp_id;
    logic              idle;

    adder_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW), .ADD_LAT(1)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_1_i(d1),
        .req_data_2_i(d2),
        .add_data_1_o(add_d1),
        .add_data_2_o(add_d2),
        .add_sum_i   (add_sum),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum),
        .rsp_id_o    (rsp_id),
        .idle_o      (idle)
    );

    // Shared adder: registered, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) add_sum <= '0;
        else        add_sum <= {1'b0, add_d1} + {1'b0, add_d2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] sum;
        int          id;
        int          avail;
    } rsp_t;

    rsp_t            q[$];
    int              mptr;
    int              cyc;
    int              checks;
    int              errors;
    logic [NREQ-1:0] obs_ready;
    logic [16:0]     last_sum;
    int              last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        d1 = {$urandom(), $urandom()};
        d2 = {$urandom(), $urandom()};
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic rr);
        int          g;
        int          c;
        logic        ev;
        logic        pop;
        logic        iss;
        logic [NREQ-1:0] er;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [16:0] es;
        int          eid;
        req_valid = v;
        rsp_ready = rr;
        @(negedge clk);
        ev  = (q.size() > 0) && (q[0].avail <= cyc);
        pop = ev && rr;
        g   = -1;
        for (int k = 0; k < NREQ; k++) begin
            c = (mptr + k) % NREQ;
            if (g < 0 && v[c]) g = c;
        end
        iss = (g >= 0) && (q.size() - int'(pop) < 2);
        er  = '0;
        e1  = '0;
        e2  = '0;
        if (iss) begin
            er[g] = 1'b1;
            e1 = d1[g*16 +: 16];
            e2 = d2[g*16 +: 16];
        end
        es  = ev ? q[0].sum : '0;
        eid = ev ? q[0].id : 0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("add_data_1", 32'(add_d1), 32'(e1));
        chk("add_data_2", 32'(add_d2), 32'(e2));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_sum", 32'(rsp_sum), 32'(es));
        chk("rsp_id", 32'(rsp_id), 32'(eid));
        chk("idle", 32'(idle), 32'(q.size() == 0));
        obs_ready = req_ready;
        if (rsp_valid && rr) begin
            last_sum = rsp_sum;
            last_id  = int'(rsp_id);
        end
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (iss) begin
            rsp_t r;
            r.sum   = {1'b0, e1} + {1'b0, e2};
            r.id    = g;
            r.avail = cyc + 2;
            q.push_back(r);
            mptr = (g + 1) % NREQ;
        end
        cyc++;
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_add1"}, 32'(add_d1), 32'(0));
        chk({tag, "_add2"}, 32'(add_d2), 32'(0));
        chk({tag, "_rvalid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsum"}, 32'(rsp_sum), 32'(0));
        chk({tag, "_rid"}, 32'(rsp_id), 32'(0));
        chk({tag, "_idle"}, 32'(idle), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        checks    = 0;
        errors    = 0;
        mptr      = 0;
        cyc       = 0;
        last_sum  = '0;
        last_id   = -1;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        d1        = '0;
        d2        = '0;
        #1;
        chk_reset_vals("rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 2 with carry-out
        d1[2*16 +: 16] = 16'h0001;
        d2[2*16 +: 16] = 16'hFFFF;
        step(4'b0100, 1'b1);
        chk("single_grant", 32'(obs_ready), 32'h4);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("single_sum", 32'(last_sum), 32'h10000);
        chk("single_id", 32'(last_id), 32'd2);
        step(4'b0000, 1'b1);

        // Pointer wrap
        rand_data();
        step(4'b1000, 1'b1);
        chk("wrap_g3", 32'(obs_ready), 32'h8);
        step(4'b1010, 1'b1);
        chk("wrap_g1", 32'(obs_ready), 32'h2);
        step(4'b1010, 1'b1);
        chk("wrap_g3b", 32'(obs_ready), 32'h8);
        repeat (3) step(4'b0000, 1'b1);

        // Fairness
        for (int k = 0; k < 8; k++) begin
            rand_data();
            step(4'b1111, 1'b1);
            chk("fair_grant", 32'(obs_ready), 32'(1 << (k % 4)));
        end
        repeat (3) step(4'b0000, 1'b1);

        // Back-pressure
        acc = 0;
        rand_data();
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 1'b0);
            if (obs_ready != '0) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        step(4'b1111, 1'b1);
        chk("bp_resume", 32'(obs_ready != '0), 32'd1);
        repeat (4) step(4'b0000, 1'b1);

        // Max operands
        d1[0 +: 16] = 16'hFFFF;
        d2[0 +: 16] = 16'hFFFF;
        step(4'b0001, 1'b1);
        repeat (3) step(4'b0000, 1'b1);
        chk("max_sum", 32'(last_sum), 32'h1FFFE);

        // Async reset with two adds in flight
        rand_data();
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        q.delete();
        mptr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(4'b0000, 1'b1);
        d1[3*16 +: 16] = 16'h1234;
        d2[3*16 +: 16] = 16'h4321;
        step(4'b1000, 1'b1);
        repeat (3) step(4'b0000, 1'b1);
        chk("post_rst_sum", 32'(last_sum), 32'h5555);
        chk("post_rst_id", 32'(last_id), 32'd3);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            rand_data();
            step(4'($urandom_range(0, 15)), logic'($urandom_range(0, 9) < 7));
        end
        repeat (5) step(4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares the single registered 16-bit adder (16+16 -> 17-bit sum, one-cycle latency, 17-bit result) among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block drives the adder operand inputs, tracks the requester id of every in-flight add, and returns each sum with its id on one shared response channel. A response FIFO and credit check give full throughput with no result ever dropped under back-pressure. It sits between the IDCT datapath clients and the shared adder instance.

## Interface
- NUM_REQ, 4, number of requesters, legal range 2..8
- ID_W, 2, requester-id width; 2^ID_W >= NUM_REQ
- ADD_LAT, 1, adder latency in cycles, from operands driven to sum valid
- RSP_DEPTH (localparam), ADD_LAT+1, response FIFO depth
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  reset; one clock, asynchronous assert, active-low (fixed)
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
- req_data_1_i  in  NUM_REQ*16  operand 1; requester i occupies bits [16i+15:16i]
- req_data_2_i  in  NUM_REQ*16  operand 2; same packing as operand 1
- add_data_1_o  out  16  operand 1 to the adder
- add_data_2_o  out  16  operand 2 to the adder
- add_sum_i  in  17  sum from the adder
- rsp_valid_o  out  1  response valid (FIFO not empty)
- rsp_ready_i  in  1  response consumer ready
- rsp_sum_o  out  17  response sum (FIFO head)
- rsp_id_o  out  ID_W  requester index that issued this sum
- idle_o  out  1  high when nothing is in flight and the FIFO is empty

## Operation
- Arbitration pointer ptr (ID_W bits) resets to 0. Priority order is ptr, ptr+1, …, wrapping modulo NUM_REQ. The grant goes to the first requester in that order whose valid is high.
- Issue condition: any valid AND (inflight_cnt + fifo_cnt − pop) < RSP_DEPTH.
  - pop = rsp_valid_o & rsp_ready_i.
  - This gives a same-cycle credit return, so there is a combinational path from rsp_ready_i to req_ready_o. This path is intended.
- On issue:
  - req_ready_o[g] = 1 and the handshake completes that cycle.
  - add_data_x_o carry the muxed operands of requester g.
  - Tag {1, g} enters stage 0 of an ADD_LAT-deep tag shift register.
  - ptr <= (g+1) mod NUM_REQ.
- With no issue: req_ready_o = 0, add_data_1_o = add_data_2_o = 0, and ptr holds.
- A tag leaving the last stage pushes {add_sum_i, id} into the FIFO. Push and pop may happen in the same cycle. fifo_cnt changes by push − pop.
- The credit rule guarantees a push never finds the FIFO full. A push into a full FIFO is an assertion failure.
- inflight_cnt is the number of valid tag stages.
- idle_o = (inflight_cnt == 0) & (fifo_cnt == 0).
- Sum width: the full 17-bit unsigned result passes through unchanged. The carry-out is never truncated.
- Responses return in issue order, because the adder is in-order and the FIFO is in-order.

## Timing
- Reset values:
  - req_ready_o = 0, add_data_x_o = 0.
  - rsp_valid_o = 0, rsp_sum_o = 0, rsp_id_o = 0.
  - idle_o = 1, ptr = 0.
  - All tags invalid; FIFO empty.
- The adder's own reset is synchronous. After rst_n_i deasserts, the first request must not be accepted before the first clock edge; the arbiter is idle on that edge anyway.
- Latency: a request accepted in cycle T gives rsp_valid_o high in cycle T+ADD_LAT+1, i.e. T+2 at the default.
- Throughput: one accept per cycle while rsp_ready_i stays high.
- Back-pressure, default parameters:
  - With rsp_ready_i low, at most 2 requests are accepted before req_ready_o goes to 0.
  - Acceptance resumes in the same cycle rsp_ready_i returns high.
- Reset mid-operation (asynchronous):
  - In-flight tags and FIFO contents are discarded and all outputs return to reset values.
  - No response is issued for adds accepted before the reset.
- A requester that drops valid without a handshake is legal. It is simply not granted.

## Test plan
- Single request: requester 2 sends 16'h0001 + 16'hFFFF, rsp_ready high -> ready[2] pulses once, then two cycles later rsp_valid = 1, sum = 17'h10000, id = 2, idle_o returns to 1.
- Fairness: all 4 valids held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle, and responses return in the same id order.
- Pointer wrap: only requesters 3 and 1 valid after a grant to 3 -> next grant is 1, then 3.
- Back-pressure: rsp_ready low with 4 valids -> exactly 2 accepts, then ready = 0 and the FIFO holds 2 entries. Raising rsp_ready -> accept in the same cycle, with no loss or duplication.
- Max operands: 16'hFFFF + 16'hFFFF -> sum = 17'h1FFFE.
- Async reset with 2 adds in flight -> all outputs go to reset values immediately. After release, no stale response appears, and a new request returns correctly.
